// File: rtl/wb_write_buffer.sv
// Write-back merge buffer: merges memory- and ALU-path register writes in program order
// into a single registered register-file write port, with forwarding over pending writes.
module wb_write_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_val,
    output logic              mem_ready,
    input  logic              alu_wr_en,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_val,
    output logic              alu_ready,
    output logic              Write_EN,
    output logic [ADDR_W-1:0] dest,
    output logic [DATA_W-1:0] Write_val,
    input  logic [ADDR_W-1:0] fwd_src,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_val,
    output logic              busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] q_dest [DEPTH];
    logic [DATA_W-1:0] q_val  [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] alu_slot;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free;
    logic [1:0]       push_cnt;
    logic             mem_push;
    logic             alu_push;
    logic             pop;

    // Room is judged on the pre-pop count, so a same-cycle pop never makes space.
    always_comb begin
        free      = DEPTH_CNT - count;
        mem_ready = (free != '0);
        alu_ready = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !mem_wr_en);
        mem_push  = mem_wr_en && mem_ready;
        alu_push  = alu_wr_en && alu_ready;
        push_cnt  = {1'b0, mem_push} + {1'b0, alu_push};
        pop       = (count != '0);
        alu_slot  = mem_push ? (wr_ptr + PTR_W'(1)) : wr_ptr;
    end

    always_ff @(posedge clk) begin
        if (mem_push) begin
            q_dest[wr_ptr] <= mem_dest;
            q_val[wr_ptr]  <= mem_val;
        end
        if (alu_push) begin
            q_dest[alu_slot] <= alu_dest;
            q_val[alu_slot]  <= alu_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            count  <= count + CNT_W'(push_cnt) - CNT_W'(pop);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Write_EN  <= 1'b0;
            dest      <= '0;
            Write_val <= '0;
        end else begin
            Write_EN <= pop;
            if (pop) begin
                dest      <= q_dest[rd_ptr];
                Write_val <= q_val[rd_ptr];
            end
        end
    end

    // Scan oldest to youngest so the last match left standing is the youngest write.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_val = '0;
        if (Write_EN && (dest == fwd_src)) begin
            fwd_hit = 1'b1;
            fwd_val = Write_val;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (q_dest[rd_ptr + PTR_W'(i)] == fwd_src)) begin
                fwd_hit = 1'b1;
                fwd_val = q_val[rd_ptr + PTR_W'(i)];
            end
        end
    end

    assign busy = (count != '0) || Write_EN;

endmodule
